// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared timing constants, colour type and total helpers for the VGA grid block
package vga_pkg;

    localparam int COORD_W = 16;

    // 640x480@60 from a 50 MHz board clock
    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_ROWS     = 8;
    localparam int DEF_COLS     = 8;
    localparam int DEF_COLOR_W  = 4;

    typedef struct packed {
        logic [DEF_COLOR_W-1:0] r;
        logic [DEF_COLOR_W-1:0] g;
        logic [DEF_COLOR_W-1:0] b;
    } rgb_t;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return axis_total(active, fp, sync, bp);
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return axis_total(active, fp, sync, bp);
    endfunction

    localparam int DEF_H_TOTAL = h_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL = v_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_grid_timing_if.sv
// rtl/vga_grid_timing_if.sv - pixel/cell bus between the timing generator and game logic / DAC
interface vga_grid_timing_if
    import vga_pkg::*;
#(
    parameter int COLOR_W = DEF_COLOR_W,
    parameter int ROWS    = DEF_ROWS,
    parameter int COLS    = DEF_COLS
) ();
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    logic [3*COLOR_W-1:0] cell_rgb;
    logic [ROW_W-1:0]     cell_row;
    logic [COL_W-1:0]     cell_col;
    logic [COORD_W-1:0]   px_x;
    logic [COORD_W-1:0]   px_y;
    logic                 pixel_tick;
    logic                 line_start;
    logic                 frame_start;
    logic                 h_sync;
    logic                 v_sync;
    logic                 blank_n;
    logic                 sync_n;
    logic [COLOR_W-1:0]   red;
    logic [COLOR_W-1:0]   green;
    logic [COLOR_W-1:0]   blue;

    modport master (
        input  cell_rgb,
        output cell_row, cell_col, px_x, px_y, pixel_tick, line_start, frame_start,
        output h_sync, v_sync, blank_n, sync_n, red, green, blue
    );

    modport slave (
        output cell_rgb,
        input  cell_row, cell_col, px_x, px_y, pixel_tick, line_start, frame_start,
        input  h_sync, v_sync, blank_n, sync_n, red, green, blue
    );

endinterface

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - wrapping position counter for one axis with active/sync decode
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               step,
    output logic [COORD_W-1:0] count,
    output logic               active,
    output logic               sync,
    output logic               wrap
);
    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [COORD_W-1:0] LAST    = COORD_W'(TOTAL - 1);
    localparam logic [COORD_W-1:0] ACT_END = COORD_W'(ACTIVE);
    localparam logic [COORD_W-1:0] SYNC_LO = COORD_W'(ACTIVE + FP);
    localparam logic [COORD_W-1:0] SYNC_HI = COORD_W'(ACTIVE + FP + SYNC);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= '0;
        end else if (step) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

    assign wrap   = (count == LAST);
    assign active = (count < ACT_END);
    assign sync   = (count >= SYNC_LO) && (count < SYNC_HI);

endmodule

// File: rtl/vga_grid_timing.sv
// rtl/vga_grid_timing.sv - VGA timing generator with grid-cell addressing and registered RGB
module vga_grid_timing
    import vga_pkg::*;
#(
    parameter int                   CLK_DIV  = DEF_CLK_DIV,
    parameter int                   H_ACTIVE = DEF_H_ACTIVE,
    parameter int                   H_FP     = DEF_H_FP,
    parameter int                   H_SYNC   = DEF_H_SYNC,
    parameter int                   H_BP     = DEF_H_BP,
    parameter int                   V_ACTIVE = DEF_V_ACTIVE,
    parameter int                   V_FP     = DEF_V_FP,
    parameter int                   V_SYNC   = DEF_V_SYNC,
    parameter int                   V_BP     = DEF_V_BP,
    parameter bit                   SYNC_POL = 1'b0,
    parameter int                   ROWS     = DEF_ROWS,
    parameter int                   COLS     = DEF_COLS,
    parameter int                   COLOR_W  = DEF_COLOR_W,
    parameter bit                   GRID_EN  = 1'b1,
    parameter logic [3*COLOR_W-1:0] GRID_RGB = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
    vga_grid_timing_if.master vga
);
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CELL_W = H_ACTIVE / COLS;
    localparam int CELL_H = V_ACTIVE / ROWS;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    if (H_ACTIVE % COLS != 0) begin : g_bad_cols
        $error("H_ACTIVE must be a multiple of COLS");
    end
    if (V_ACTIVE % ROWS != 0) begin : g_bad_rows
        $error("V_ACTIVE must be a multiple of ROWS");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("CLK_DIV must be in 1..16");
    end

    logic [DIV_W-1:0]     div;
    logic                 tick_q;
    logic                 step;
    logic [COORD_W-1:0]   px_x, px_y, nx, ny;
    logic                 h_active, h_in_sync, h_wrap;
    logic                 v_active, v_in_sync, v_wrap;
    logic [COORD_W-1:0]   col_sub, row_sub;
    logic [COL_W-1:0]     cell_col;
    logic [ROW_W-1:0]     cell_row;
    logic                 px_active, on_border;
    logic [3*COLOR_W-1:0] rgb_next, rgb_q;
    logic                 h_sync_q, v_sync_q, blank_q;

    // tick is registered so it is low in reset even when CLK_DIV is 1
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            div    <= '0;
            tick_q <= 1'b0;
        end else if (enable) begin
            tick_q <= (div == DIV_LAST);
            div    <= (div == DIV_LAST) ? '0 : div + 1'b1;
        end else begin
            tick_q <= 1'b0;
        end
    end

    assign step = tick_q && enable;

    vga_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h_counter (
        .clock  (clock),
        .reset_n(reset_n),
        .step   (step),
        .count  (px_x),
        .active (h_active),
        .sync   (h_in_sync),
        .wrap   (h_wrap)
    );

    vga_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v_counter (
        .clock  (clock),
        .reset_n(reset_n),
        .step   (step && h_wrap),
        .count  (px_y),
        .active (v_active),
        .sync   (v_in_sync),
        .wrap   (v_wrap)
    );

    assign nx = h_wrap ? '0 : px_x + 1'b1;
    assign ny = h_wrap ? (v_wrap ? '0 : px_y + 1'b1) : px_y;

    // Cell address follows the counters; it only moves when the next pixel is visible
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cell_col <= '0;
            col_sub  <= '0;
            cell_row <= '0;
            row_sub  <= '0;
        end else if (step && nx < COORD_W'(H_ACTIVE) && ny < COORD_W'(V_ACTIVE)) begin
            if (nx == '0) begin
                cell_col <= '0;
                col_sub  <= '0;
            end else if (col_sub == COORD_W'(CELL_W - 1)) begin
                cell_col <= cell_col + 1'b1;
                col_sub  <= '0;
            end else begin
                col_sub <= col_sub + 1'b1;
            end
            if (h_wrap) begin
                if (ny == '0) begin
                    cell_row <= '0;
                    row_sub  <= '0;
                end else if (row_sub == COORD_W'(CELL_H - 1)) begin
                    cell_row <= cell_row + 1'b1;
                    row_sub  <= '0;
                end else begin
                    row_sub <= row_sub + 1'b1;
                end
            end
        end
    end

    assign px_active = h_active && v_active;
    assign on_border = (col_sub == '0) || (row_sub == '0);

    always_comb begin
        rgb_next = '0;
        if (px_active) begin
            rgb_next = (GRID_EN && on_border) ? GRID_RGB : vga.cell_rgb;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            h_sync_q <= ~SYNC_POL;
            v_sync_q <= ~SYNC_POL;
            blank_q  <= 1'b0;
            rgb_q    <= '0;
        end else if (!enable) begin
            blank_q <= 1'b0;
            rgb_q   <= '0;
        end else if (step) begin
            h_sync_q <= h_in_sync ? SYNC_POL : ~SYNC_POL;
            v_sync_q <= v_in_sync ? SYNC_POL : ~SYNC_POL;
            blank_q  <= px_active;
            rgb_q    <= rgb_next;
        end
    end

    assign vga.cell_row    = cell_row;
    assign vga.cell_col    = cell_col;
    assign vga.px_x        = px_x;
    assign vga.px_y        = px_y;
    assign vga.pixel_tick  = step;
    assign vga.line_start  = step && (px_x == '0);
    assign vga.frame_start = step && (px_x == '0) && (px_y == '0);
    assign vga.h_sync      = h_sync_q;
    assign vga.v_sync      = v_sync_q;
    assign vga.blank_n     = blank_q;
    assign vga.sync_n      = 1'b0;
    assign vga.red         = rgb_q[3*COLOR_W-1 -: COLOR_W];
    assign vga.green       = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign vga.blue        = rgb_q[COLOR_W-1:0];

endmodule
